// File: rtl/fifo_pkg.sv
// Shared widths, header field layout and parser state encoding for the FIFO
// packet reader and its output buffer.
package fifo_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;

    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_MSB = HDR_LEN_LSB + LEN_W - 1;

    typedef enum logic {
        ST_HDR     = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer holding tagged words between the FIFO pop and the
// downstream stream; slot0 is always the head.
module fifo_reader_skid #(
    parameter int unsigned W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   occ_q;
    logic [1:0]   occ_next;
    logic [1:0]   wr_idx;

    always_comb begin
        wr_idx   = occ_q - {1'b0, pop};
        occ_next = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // A push landing in slot0 is written after the shift so it takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0 <= '0;
            slot1 <= '0;
            occ_q <= '0;
        end else begin
            occ_q <= occ_next;
            if (pop) begin
                slot0 <= slot1;
                slot1 <= '0;
            end
            if (push) begin
                if (wr_idx == 2'd0) begin
                    slot0 <= push_data;
                end else begin
                    slot1 <= push_data;
                end
            end
        end
    end

    assign head = slot0;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Pops length-prefixed packets from the FIFO read port and presents them on a
// valid/ready stream tagged with header and last markers.
module fifo_pkt_reader #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W,
    parameter int unsigned LEN_W  = fifo_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_hdr,
    output logic              m_last,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    import fifo_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  rem_next;
    logic [LEN_W-1:0]  len;
    logic              hdr_tag;
    logic              last_tag;
    logic              deq;
    logic [1:0]        occ;
    logic [DATA_W+1:0] push_beat;
    logic [DATA_W+1:0] head;

    assign len = fifo_data[HDR_LEN_LSB +: LEN_W];

    // Gated on registered occupancy only, so m_ready never reaches fifo_read.
    assign fifo_read = reset & enable & ~fifo_empty & (occ != 2'd2);
    assign m_valid   = (occ != 2'd0);
    assign deq       = m_valid & m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HDR;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_comb begin
        state_next = state;
        rem_next   = rem;
        hdr_tag    = 1'b0;
        last_tag   = 1'b0;
        case (state)
            ST_HDR: begin
                hdr_tag  = 1'b1;
                last_tag = (len == '0);
                if (fifo_read && (len != '0)) begin
                    state_next = ST_PAYLOAD;
                    rem_next   = len;
                end
            end
            ST_PAYLOAD: begin
                last_tag = (rem == LEN_W'(1));
                if (fifo_read) begin
                    rem_next = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state_next = ST_HDR;
                    end
                end
            end
            default: begin
                state_next = ST_HDR;
                rem_next   = '0;
            end
        endcase
    end

    assign push_beat = {hdr_tag, last_tag, fifo_data};

    fifo_reader_skid #(
        .W(DATA_W + 2)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_read),
        .push_data (push_beat),
        .pop       (deq),
        .head      (head),
        .occ       (occ)
    );

    assign m_hdr  = head[DATA_W+1];
    assign m_last = head[DATA_W];
    assign m_data = head[DATA_W-1:0];
    assign busy   = (state == ST_PAYLOAD) | (occ != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else if (deq && m_last) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader with a FIFO model and a tagged-beat scoreboard.
module tb_fifo_pkt_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_hdr;
    logic        m_last;
    logic        busy;
    logic [15:0] pkt_count;

    fifo_pkt_reader #(
        .DATA_W(32),
        .LEN_W (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_hdr      (m_hdr),
        .m_last     (m_last),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [33:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mdl_in_pay = 1'b0;
    int unsigned mdl_rem = 0;
    int unsigned pops = 0;
    int unsigned rd_run = 0;
    int unsigned rd_run_max = 0;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
    endtask

    // Reference parser: tags each word as it enters the FIFO.
    task automatic push_word(input logic [31:0] w);
        logic [7:0] n;
        fifo_q.push_back(w);
        if (!mdl_in_pay) begin
            n = w[7:0];
            exp_q.push_back({1'b1, (n == 8'd0), w});
            if (n != 8'd0) begin
                mdl_in_pay = 1'b1;
                mdl_rem    = n;
            end
        end else begin
            exp_q.push_back({1'b0, (mdl_rem == 1), w});
            mdl_rem--;
            if (mdl_rem == 0) mdl_in_pay = 1'b0;
        end
        refresh();
    endtask

    task automatic tick();
        logic        fire;
        logic [33:0] e;
        @(negedge clk);
        if (fifo_empty) check("no_read_when_empty", {33'd0, fifo_read}, 34'd0);
        fire = fifo_read;
        if (fire) begin
            pops++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
        end else begin
            rd_run = 0;
        end
        if (m_valid && m_ready) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_beat: got %h want none", {m_hdr, m_last, m_data});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", {m_hdr, m_last, m_data}, e);
            end
        end
        @(posedge clk);
        #1;
        if (fire && fifo_q.size() > 0) fifo_q.delete(0);
        refresh();
    endtask

    task automatic drain(input string tag, input int maxc);
        int c = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && c < maxc) begin
            tick();
            c++;
        end
        total++;
        assert (exp_q.size() == 0 && fifo_q.size() == 0) else begin
            bad++;
            $error("FAIL %s: got %0d beats pending want 0", tag, exp_q.size());
        end
    endtask

    initial begin
        // reset values, with words already waiting in the FIFO
        #2;
        push_word(32'h0000_0002);
        push_word(32'h0000_000A);
        push_word(32'h0000_000B);
        tick();
        tick();
        check("rst_m_valid",   {33'd0, m_valid},   34'd0);
        check("rst_m_data",    {2'd0, m_data},     34'd0);
        check("rst_m_hdr",     {33'd0, m_hdr},     34'd0);
        check("rst_m_last",    {33'd0, m_last},    34'd0);
        check("rst_pkt_count", {18'd0, pkt_count}, 34'd0);
        check("rst_busy",      {33'd0, busy},      34'd0);
        check("rst_fifo_read", {33'd0, fifo_read}, 34'd0);

        // N=2 packet at full rate
        reset = 1'b1;
        enable = 1'b1;
        m_ready = 1'b1;
        pops = 0;
        rd_run = 0;
        rd_run_max = 0;
        drain("n2_drain", 20);
        check("n2_read_run", 34'(rd_run_max), 34'd3);
        check("n2_pops", 34'(pops), 34'd3);
        check("n2_pkt_count", {18'd0, pkt_count}, 34'd1);
        check("n2_busy", {33'd0, busy}, 34'd0);

        // N=0 single-beat packet
        pops = 0;
        push_word(32'h1234_5600);
        drain("n0_drain", 10);
        check("n0_pops", 34'(pops), 34'd1);
        check("n0_pkt_count", {18'd0, pkt_count}, 34'd2);
        check("n0_busy", {33'd0, busy}, 34'd0);

        // backpressure: only two words popped ahead, head held stable
        m_ready = 1'b0;
        pops = 0;
        push_word(32'h0000_0003);
        push_word(32'h0000_0011);
        push_word(32'h0000_0022);
        push_word(32'h0000_0033);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {m_valid, m_hdr, m_data}, {1'b1, 1'b1, 32'h0000_0003});
        end
        check("bp_pops", 34'(pops), 34'd2);
        check("bp_fifo_read", {33'd0, fifo_read}, 34'd0);
        m_ready = 1'b1;
        drain("bp_drain", 20);
        check("bp_pkt_count", {18'd0, pkt_count}, 34'd3);

        // FIFO runs dry mid-packet, then refills
        pops = 0;
        push_word(32'h0000_0003);
        push_word(32'h0000_00C1);
        for (int i = 0; i < 6; i++) tick();
        check("dry_pops", 34'(pops), 34'd2);
        check("dry_busy", {33'd0, busy}, 34'd1);
        check("dry_m_valid", {33'd0, m_valid}, 34'd0);
        push_word(32'h0000_00C2);
        push_word(32'h0000_00C3);
        drain("dry_drain", 20);
        check("dry_pkt_count", {18'd0, pkt_count}, 34'd4);
        check("dry_busy_end", {33'd0, busy}, 34'd0);

        // asynchronous reset with rem=2 and two words buffered
        m_ready = 1'b0;
        pops = 0;
        push_word(32'h0000_0003);
        push_word(32'h0000_00D1);
        for (int i = 0; i < 3; i++) tick();
        check("mid_pops", 34'(pops), 34'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {m_valid, m_hdr, m_last, busy, fifo_read, pkt_count},
              {5'b0, 16'h0});
        check("mid_rst_data", {2'd0, m_data}, 34'd0);
        exp_q.delete();
        mdl_in_pay = 1'b0;
        mdl_rem = 0;
        tick();
        reset = 1'b1;
        m_ready = 1'b1;
        push_word(32'h0000_0001);
        push_word(32'h0000_0055);
        drain("mid_drain", 20);
        check("mid_pkt_count", {18'd0, pkt_count}, 34'd1);
        check("mid_busy", {33'd0, busy}, 34'd0);

        // pkt_count wrap
        for (int i = 0; i < 65534; i++) push_word(32'(i) << 8);
        drain("wrap_drain", 66000);
        check("wrap_ffff", {18'd0, pkt_count}, 34'h0FFFF);
        push_word(32'hABCD_EF00);
        drain("wrap_last", 10);
        check("wrap_zero", {18'd0, pkt_count}, 34'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side engine for the team's 32-bit synchronous FIFO. It pops words from the FIFO read port and never issues a read while the FIFO is empty, so it cannot trigger the FIFO read-error flag. It parses a length-prefixed packet framing and presents words on a valid/ready stream with header and last tags. It sits between the FIFO and any downstream consumer that needs packet boundaries and backpressure.

## Interface
- DATA_W, 32, FIFO/stream word width
- LEN_W, 8, width of header length field (payload words per packet)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  permits new pops; deassertion does not flush buffered words
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  DATA_W  FIFO head word; combinational, valid while fifo_empty=0
- fifo_read  out  1  pop strobe to FIFO; a pop occurs at the clock edge where it is high
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accepts when m_valid & m_ready
- m_data  out  DATA_W  stream word
- m_hdr  out  1  current word is a packet header
- m_last  out  1  current word ends a packet
- busy  out  1  mid-packet or buffer non-empty
- pkt_count  out  16  packets fully delivered (last-tagged words accepted); wraps

## Operation
- Framing: header word, then N payload words; N = header[LEN_W-1:0]. Upper header bits are ignored by the parser and passed through unchanged.
- States: ST_HDR (reset), ST_PAYLOAD. Counter rem is LEN_W bits.
- Pop in ST_HDR with N=0: tag hdr=1, last=1; stay in ST_HDR.
- Pop in ST_HDR with N>0: tag hdr=1, last=0; rem<=N; go to ST_PAYLOAD.
- Pop in ST_PAYLOAD: tag hdr=0, last=(rem==1); rem<=rem-1; return to ST_HDR when rem==1.
- Tags are computed at pop time and stored with the data. Parser state advances only on pops.
- Output buffer: 2 entries, occupancy occ in 0..2. Head entry drives m_data/m_hdr/m_last. m_valid = (occ!=0).
- fifo_read = reset & enable & ~fifo_empty & (occ<2). It uses registered occ only; there is no combinational path from m_ready.
- occ_next = occ + pop - (m_valid & m_ready). A popped word is written to slot (occ - deq). On dequeue, slot1 shifts to slot0.
- pkt_count increments on each accepted word with last=1 (16-bit, wraps 0xFFFF->0x0000).
- busy = (state==ST_PAYLOAD) | (occ!=0).
- enable low mid-packet: the parser holds state and rem. Buffered words still drain.

## Timing
- Reset values: m_valid=0, m_data=0, m_hdr=0, m_last=0, pkt_count=0, busy=0, fifo_read=0, state=ST_HDR, rem=0, occ=0.
- Asynchronous reset mid-packet discards buffered words and parser state immediately. The first word popped after release is treated as a header.
- Latency: head word present with fifo_read=1 at edge t, then the word is on m_data with m_valid=1 in the cycle after t.
- Throughput: 1 word/cycle sustained while m_ready=1 and the FIFO is non-empty.
- Backpressure: m_data and tags are held stable while m_valid & ~m_ready. At most 2 words are popped ahead of the consumer.
- Simultaneous pop and dequeue at occ=2 cannot occur, because the pop is gated by occ<2.
- Simultaneous pop and dequeue at occ=1 leaves occ at 1, with the new word in slot0.
- Simultaneous pop and dequeue at occ=0 cannot occur, because m_valid=0.

## Structure
- Package fifo_pkg: DATA_W, LEN_W, localparams ST_HDR/ST_PAYLOAD, header length field LSB/MSB constants.
- Sub-module fifo_reader_skid: 2-entry buffer carrying {hdr, last, data}, with push/pop/occ. The parent holds the parser, the fifo_read logic and pkt_count.

## Test plan
- Header N=2, payloads 0xA, 0xB in FIFO, m_ready=1 -> fifo_read high 3 consecutive cycles. Stream emits header(hdr=1), 0xA, 0xB(last=1). pkt_count=1, busy=0 afterwards.
- Header 0x1234_5600 (N=0) -> single beat: m_hdr=1, m_last=1, m_data=0x1234_5600. pkt_count increments; state remains ST_HDR.
- 4 words queued, m_ready=0 for 5 cycles -> exactly 2 pops, then fifo_read=0 and m_data stable. After m_ready=1, all 4 words are delivered in order with no loss or duplication.
- FIFO empties after header N=3 and 1 payload word -> fifo_read never high while fifo_empty=1; busy=1, state ST_PAYLOAD. Refilling completes the packet with last on the 3rd payload word.
- reset asserted mid-packet (rem=2) -> all outputs zero immediately. After release, the next word 0x0000_0001 is parsed as a header with N=1.
- 65536 N=0 packets -> pkt_count wraps from 0xFFFF to 0x0000.
